// File: rtl/bin2bcd.sv
// bin2bcd -- sequential binary to packed-BCD converter (double dabble).
//
// Converts an unsigned W-bit operand to an OW-bit packed BCD word, least
// significant digit in bcd[3:0]. The default build is iterative: it processes
// one input bit per clock, and out_valid rises W clocks after acceptance.
//
// Build option BIN2BCD_FAST_EN: convert through a fully unrolled
// combinational network. The result is registered on the acceptance edge,
// out_valid is high in the following cycle, and in_ready is tied high.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   conversion request
//   in_ready   request can be accepted this cycle
//   bin[W]     unsigned operand, sampled on the acceptance edge only
//   bcd[OW]    packed BCD result, held until the next completion or reset
//   out_valid  one-cycle strobe marking a new bcd value
module bin2bcd #(
  parameter  int unsigned W  = 8,
  localparam int unsigned OW = W + (W - 4) / 3 + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  bin,
  output logic [OW-1:0] bcd,
  output logic          out_valid
);

  // The BCD field is rounded up to whole nibbles so that the add-3 correction
  // of the top (possibly truncated) digit can never carry out of the field.
  localparam int unsigned BW = 4 * ((OW + 3) / 4);
  localparam int unsigned RW = BW + W;

  // One double-dabble step on the {bcd, binary} working register: correct
  // every BCD nibble >= 5, then shift the whole register left by one.
  function automatic logic [RW-1:0] dabble_step(input logic [RW-1:0] v);
    logic [RW-1:0] t;
    t = v;
    for (int unsigned i = 0; i < BW / 4; i++) begin
      if (t[W + 4*i +: 4] >= 4'd5) begin
        t[W + 4*i +: 4] = t[W + 4*i +: 4] + 4'd3;
      end
    end
    return t << 1;
  endfunction

  logic [OW-1:0] r_bcd;

  assign bcd = r_bcd;

`ifdef BIN2BCD_FAST_EN

  function automatic logic [OW-1:0] convert(input logic [W-1:0] b);
    logic [RW-1:0] v;
    v = {{BW{1'b0}}, b};
    for (int unsigned i = 0; i < W; i++) begin
      v = dabble_step(v);
    end
    return v[W +: OW];
  endfunction

  logic r_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bcd   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_bcd <= convert(bin);
      end
    end
  end

  assign in_ready  = 1'b1;
  assign out_valid = r_valid;

`else

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  localparam int unsigned CW = $clog2(W + 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [RW-1:0] r_work;
  logic [RW-1:0] w_step;
  logic          w_accept;
  logic          w_last;

  assign w_step    = dabble_step(r_work);
  assign in_ready  = (r_state != S_SHIFT);
  assign out_valid = (r_state == S_DONE);
  assign w_accept  = in_valid & in_ready;
  assign w_last    = (r_cnt == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_last)   w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = in_valid ? S_SHIFT : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Working register and result. bcd is loaded only from the final shift so
  // intermediate values are never visible on the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_work <= '0;
      r_cnt  <= '0;
      r_bcd  <= '0;
    end else if (w_accept) begin
      r_work <= {{BW{1'b0}}, bin};
      r_cnt  <= CW'(W);
    end else if (r_state == S_SHIFT) begin
      r_work <= w_step;
      r_cnt  <= r_cnt - CW'(1);
      if (w_last) begin
        r_bcd <= w_step[W +: OW];
      end
    end
  end

`endif

endmodule

// File: tb/tb_bin2bcd.sv
// Testbench for bin2bcd: W=8 and W=16 instances against a decimal-digit
// reference model; adapts latency and ready expectations to BIN2BCD_FAST_EN.
module tb_bin2bcd;

`ifdef BIN2BCD_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  // Edges after the acceptance edge until out_valid is seen high.
  localparam int L8  = FAST ? 0 : 8;
  localparam int L16 = FAST ? 0 : 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid8, in_ready8, out_valid8;
  logic [7:0]  bin8;
  logic [9:0]  bcd8;
  logic        in_valid16, in_ready16, out_valid16;
  logic [15:0] bin16;
  logic [20:0] bcd16;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bin2bcd #(.W(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .bin(bin8), .bcd(bcd8), .out_valid(out_valid8)
  );

  bin2bcd #(.W(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .bin(bin16), .bcd(bcd16), .out_valid(out_valid16)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: decimal digits by repeated division, one nibble per digit.
  function automatic logic [63:0] ref_bcd(input longint unsigned v);
    logic [63:0] r;
    longint unsigned x;
    r = '0;
    x = v;
    for (int d = 0; d < 16; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic get_ov(input bit wide);
    return wide ? out_valid16 : out_valid8;
  endfunction

  function automatic logic get_rdy(input bit wide);
    return wide ? in_ready16 : in_ready8;
  endfunction

  function automatic logic [63:0] get_bcd(input bit wide);
    return wide ? 64'(bcd16) : 64'(bcd8);
  endfunction

  task automatic set_req(input bit wide, input logic v, input logic [15:0] b);
    if (wide) begin
      in_valid16 = v;
      bin16      = b;
    end else begin
      in_valid8 = v;
      bin8      = b[7:0];
    end
  endtask

  // Called 1 time unit after the acceptance edge; waits (bounded) for the strobe.
  task automatic wait_strobe(input bit wide, input int lat, input logic [63:0] exp,
                             input string tag);
    int k;
    bit seen;
    k    = 0;
    seen = 1'b0;
    while (!seen && k <= lat + 4) begin
      if (get_ov(wide)) begin
        seen = 1'b1;
      end else begin
        if (k < lat) check({tag, "_busy_rdy"}, get_rdy(wide), FAST ? 1 : 0);
        @(posedge clk); #1;
        k++;
      end
    end
    check({tag, "_seen"}, seen, 1);
    check({tag, "_lat"}, k, lat);
    check({tag, "_bcd"}, get_bcd(wide), exp);
    check({tag, "_done_rdy"}, get_rdy(wide), 1);
  endtask

  task automatic convert_one(input bit wide, input logic [15:0] b, input string tag);
    set_req(wide, 1'b1, b);
    @(posedge clk); #1;
    // operand changes after acceptance must not matter
    set_req(wide, 1'b0, 16'($urandom));
    wait_strobe(wide, wide ? L16 : L8, ref_bcd(longint'(b)), tag);
    @(posedge clk); #1;
    check({tag, "_fall"}, get_ov(wide), 0);
  endtask

  int unsigned sweep [14] = '{0, 1, 4, 5, 7, 8, 9, 10, 20, 90, 99, 100, 200, 255};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int stray;
    logic [15:0] r;
    rst_n = 1'b0;
    set_req(1'b0, 1'b0, 16'h0);
    set_req(1'b1, 1'b0, 16'h0);
    @(posedge clk); #1;
    check("rst_bcd8", bcd8, 0);
    check("rst_ov8", out_valid8, 0);
    check("rst_rdy8", in_ready8, 1);
    check("rst_bcd16", bcd16, 0);
    check("rst_ov16", out_valid16, 0);
    check("rst_rdy16", in_ready16, 1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    convert_one(1'b0, 16'd243, "d243");
    foreach (sweep[i]) convert_one(1'b0, 16'(sweep[i]), $sformatf("sw%0d", sweep[i]));
    for (int i = 0; i < 30; i++) begin
      r = 16'($urandom_range(255));
      convert_one(1'b0, r, $sformatf("rnd8_%0d", r));
    end

    convert_one(1'b1, 16'd65244, "d65244");
    convert_one(1'b1, 16'd65535, "d65535");
    for (int i = 0; i < 8; i++) begin
      r = 16'($urandom_range(65535));
      convert_one(1'b1, r, $sformatf("rnd16_%0d", r));
    end

    // Back-to-back: second request accepted in the strobe cycle. In the
    // iterative build in_valid stays high through SHIFT and must be ignored.
    set_req(1'b0, 1'b1, 16'd100);
    @(posedge clk); #1;
    set_req(1'b0, !FAST, 16'd99);
    wait_strobe(1'b0, L8, ref_bcd(100), "b2b_first");
    set_req(1'b0, 1'b1, 16'd99);
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 16'd7);
    if (!FAST) check("b2b_fall", out_valid8, 0);
    wait_strobe(1'b0, L8, ref_bcd(99), "b2b_second");
    stray = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid8) stray++;
    end
    check("b2b_no_extra", stray, 0);

    // Reset in the middle of a 255 conversion.
    set_req(1'b0, 1'b1, 16'd255);
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 16'd0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check("mid_rst_bcd8", bcd8, 0);
    check("mid_rst_ov8", out_valid8, 0);
    check("mid_rst_rdy8", in_ready8, 1);
    check("mid_rst_bcd16", bcd16, 0);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    stray = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid8) stray++;
    end
    check("mid_rst_no_stale", stray, 0);
    check("mid_rst_bcd_hold", bcd8, 0);
    check("mid_rst_rdy_after", in_ready8, 1);
    convert_one(1'b0, 16'd42, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
